// File: rtl/rv32i_alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU opcodes and arbiter state encoding.
package rv32i_alu_arbiter_pkg;

    localparam int XLEN_SUPPORTED = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rv32i_alu_arbiter_alu.sv
// Purely combinational RV32I integer ALU; unknown opcodes yield zero.
module rv32i_alu
    import rv32i_alu_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // Opcode decode and result select.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rv32i_alu_arbiter.sv
// Shares one rv32i_alu between the execute stage (port 0) and the address/branch unit (port 1).
// Grant is round-robin or fixed priority; the result is registered and held until consumed.
module rv32i_alu_arbiter
    import rv32i_alu_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [3:0]      req0_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    output logic            rsp0_zero,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [3:0]      req1_op,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic            rsp1_zero,
    output logic            busy
);

    arb_state_e      state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic            owner_q, owner_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            grant;
    logic            any_valid;
    logic            idle;
    logic            owner_rsp_ready;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [3:0]      alu_op;
    logic            alu_zero;

    assign any_valid = req0_valid | req1_valid;
    assign idle      = (state_q == ARB_IDLE);

    // Port 1 wins when it is alone, or on a collision when round-robin favours it.
    assign grant = req1_valid & (~req0_valid | ((FIXED_PRIO == 0) & rr_ptr_q));

    assign req0_ready = rst_n & idle & req0_valid & ~grant;
    assign req1_ready = rst_n & idle & req1_valid & grant;

    assign alu_a  = grant ? req1_a  : req0_a;
    assign alu_b  = grant ? req1_b  : req0_b;
    assign alu_op = grant ? req1_op : req0_op;

    rv32i_alu #(.XLEN(XLEN)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state: capture the granted operation on accept, release on owner consume.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_valid) begin
                    state_d  = ARB_RESP;
                    owner_d  = grant;
                    result_d = alu_result;
                    zero_d   = alu_zero;
                    if (FIXED_PRIO == 0) rr_ptr_d = ~grant;
                end
            end
            ARB_RESP: begin
                if (owner_rsp_ready) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy        = (state_q == ARB_RESP);
    assign rsp0_valid  = busy & ~owner_q;
    assign rsp1_valid  = busy & owner_q;
    assign rsp0_result = rsp0_valid ? result_q : '0;
    assign rsp1_result = rsp1_valid ? result_q : '0;
    assign rsp0_zero   = rsp0_valid & zero_q;
    assign rsp1_zero   = rsp1_valid & zero_q;

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// Directed bench for rv32i_alu_arbiter: a round-robin instance and a fixed-priority
// instance share all stimulus; each scenario task checks its own expectations.
module tb_rv32i_alu_arbiter;
    import rv32i_alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, busy;
    logic [31:0] rsp0_result, rsp1_result;

    logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp0_zero, f_rsp1_zero, f_busy;
    logic [31:0] f_rsp0_result, f_rsp1_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32i_alu_arbiter #(.XLEN(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .busy(busy)
    );

    rv32i_alu_arbiter #(.XLEN(32), .FIXED_PRIO(1)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(f_rsp0_result), .rsp0_zero(f_rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(f_rsp1_result), .rsp1_zero(f_rsp1_zero),
        .busy(f_busy)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = ALU_ADD;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = ALU_ADD;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0 ||
            rsp0_result !== 32'd0 || rsp1_result !== 32'd0 || rsp0_zero !== 1'b0 || rsp1_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: v=%b%b busy=%b r0=%h r1=%h z=%b%b want all zero",
                     rsp0_valid, rsp1_valid, busy, rsp0_result, rsp1_result, rsp0_zero, rsp1_zero);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_port();
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'h5; req0_b = 32'h3; req0_op = ALU_SUB;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req0_a = 32'hDEAD; req0_b = 32'hBEEF; req0_op = ALU_OR;
        #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h2 || rsp0_zero !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_rsp: v0=%b r=%h z=%b v1=%b busy=%b want 1 00000002 0 0 1",
                     rsp0_valid, rsp0_result, rsp0_zero, rsp1_valid, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: v0=%b busy=%b want 0 0", rsp0_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic g;
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = ALU_ADD;
        req1_valid = 1'b1; req1_a = 32'hFFFFFFFF; req1_b = 32'd1; req1_op = ALU_ADD;
        for (int i = 0; i < 4; i++) begin
            g = i[0];
            #1;
            checks++;
            if (req0_ready !== ~g || req1_ready !== g) begin
                errors++;
                $display("FAIL rr_grant%0d: ready=%b%b want port %0d", i, req0_ready, req1_ready, g);
            end
            @(negedge clk);
            #1;
            checks++;
            if (g == 1'b0) begin
                if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_result !== 32'd30 || rsp0_zero !== 1'b0 ||
                    req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_rsp%0d: v=%b%b r0=%h z0=%b rdy=%b%b want 10 0000001e 0 00",
                             i, rsp0_valid, rsp1_valid, rsp0_result, rsp0_zero, req0_ready, req1_ready);
                end
            end else begin
                if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_result !== 32'd0 || rsp1_zero !== 1'b1 ||
                    rsp0_result !== 32'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_rsp%0d: v=%b%b r1=%h z1=%b r0=%h rdy=%b%b want 01 00000000 1 00000000 00",
                             i, rsp0_valid, rsp1_valid, rsp1_result, rsp1_zero, rsp0_result, req0_ready, req1_ready);
                end
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_fixed_prio();
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9; req0_op = ALU_XOR;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = ALU_ADD;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (f_req0_ready !== 1'b1 || f_req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL fixed_grant%0d: ready=%b%b want 10", i, f_req0_ready, f_req1_ready);
            end
            @(negedge clk);
            #1;
            checks++;
            if (f_rsp0_valid !== 1'b1 || f_rsp0_result !== 32'd14 || f_rsp1_valid !== 1'b0 || f_req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL fixed_rsp%0d: v=%b%b r0=%h rdy1=%b want 10 0000000e 0",
                         i, f_rsp0_valid, f_rsp1_valid, f_rsp0_result, f_req1_ready);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        apply_reset();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd1; req0_op = ALU_SUB;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd5; req1_op = ALU_XOR;
        @(negedge clk);
        req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd6 || busy !== 1'b1 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: v0=%b r0=%h busy=%b rdy1=%b want 1 00000006 1 0",
                         i, rsp0_valid, rsp0_result, busy, req1_ready);
            end
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_comb_path: rdy1=%b want 0", req1_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_port1_accept: rdy1=%b v0=%b want 1 0", req1_ready, rsp0_valid);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd6 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_port1_rsp: v1=%b r1=%h v0=%b want 1 00000006 0", rsp1_valid, rsp1_result, rsp0_valid);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] r;
        logic        z;
    } vec_t;

    task automatic test_arith_corners();
        vec_t v[7];
        v[0] = '{32'h80000000, 32'h00000021, ALU_SRA,  32'hC0000000, 1'b0};
        v[1] = '{32'h80000000, 32'h00000001, ALU_SLT,  32'h00000001, 1'b0};
        v[2] = '{32'h80000000, 32'h00000001, ALU_SLTU, 32'h00000000, 1'b1};
        v[3] = '{32'h00000003, 32'h00000021, ALU_SLL,  32'h00000006, 1'b0};
        v[4] = '{32'h80000000, 32'h0000001F, ALU_SRL,  32'h00000001, 1'b0};
        v[5] = '{32'h000000F0, 32'h0000000F, ALU_OR,   32'h000000FF, 1'b0};
        v[6] = '{32'h12345678, 32'h9ABCDEF0, 4'hF,     32'h00000000, 1'b1};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            req0_valid = 1'b1; req0_a = v[i].a; req0_b = v[i].b; req0_op = v[i].op;
            @(negedge clk);
            req0_valid = 1'b0;
            #1;
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_result !== v[i].r || rsp0_zero !== v[i].z) begin
                errors++;
                $display("FAIL arith%0d: v0=%b r=%h z=%b want 1 %h %b", i, rsp0_valid, rsp0_result, rsp0_zero, v[i].r, v[i].z);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_resp();
        apply_reset();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_op = ALU_ADD;
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd8) begin
            errors++;
            $display("FAIL mid_pre: v1=%b r1=%h want 1 00000008", rsp1_valid, rsp1_result);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0 || rsp1_result !== 32'd0) begin
            errors++;
            $display("FAIL mid_after: v=%b%b busy=%b r1=%h want 00 0 00000000", rsp0_valid, rsp1_valid, busy, rsp1_result);
        end
        rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = ALU_ADD;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_op = ALU_ADD;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_grant: ready=%b%b want 10", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = ALU_ADD;
        req1_a = '0; req1_b = '0; req1_op = ALU_ADD;
        test_reset();
        test_single_port();
        test_round_robin();
        test_fixed_prio();
        test_back_pressure();
        test_arith_corners();
        test_reset_mid_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_alu_arbiter.md
Name: rv32i_alu_arbiter

Overview:
- Shares a single rv32i_alu instance between two requesters: port 0 is the execute stage and port 1 is the address/branch-compare unit.
- Each port uses valid/ready request and response channels.
- Grant policy is round-robin, or fixed priority when configured.
- Each operation is latched at accept and its result is registered; the result is held on the winning port until that port consumes it.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins a collision.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_a  in  32  port 0 operand A.
- req0_b  in  32  port 0 operand B.
- req0_op  in  4  port 0 ALU opcode (`ALU_* codes).
- rsp0_valid  out  1  port 0 result valid.
- rsp0_ready  in  1  port 0 consumes result.
- rsp0_result  out  32  port 0 result.
- rsp0_zero  out  1  port 0 result==0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero: same as port 0, for port 1.
- busy  out  1  arbiter holds an unconsumed result.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- State machine:
  - States are IDLE and RESP.
  - Reset gives: IDLE, rr_ptr=0 (port 0 favoured), owner=0, result_q=0, zero_q=0.
  - All outputs are 0 during and after reset: req*_ready=0 while rst_n low, rsp*_valid=0, busy=0, rsp*_result=0, rsp*_zero=0.
- IDLE:
  - Grant is combinational.
  - Only one valid: that port is granted.
  - Both valid with FIXED_PRIO=1: port 0 wins.
  - Both valid with FIXED_PRIO=0: port rr_ptr wins.
  - reqN_ready = state==IDLE && grant==N && rst_n. At most one ready is high per cycle.
- Accept (valid&&ready on port g):
  - The ALU is driven with the granted a/b/op through the input mux in the same cycle.
  - On the clock edge: result_q and zero_q are captured, owner=g, and state goes to RESP.
  - In round-robin mode, rr_ptr = ~g; it updates only on accept.
- Latency: request accepted in cycle N; rsp_valid is high in cycle N+1.
- RESP:
  - rsp{owner}_valid=1 and busy=1. The other port's rsp_valid=0 and all req*_ready=0.
  - Stays in RESP until rsp{owner}_ready=1, then returns to IDLE on that edge.
  - Throughput is at most one op per 2 cycles per arbiter.
- Response data:
  - rsp{owner}_result/zero = result_q/zero_q.
  - The non-owner port's result/zero are driven 0.
  - Values are stable for the whole RESP period.
- Operands: captured at accept. Requesters may change a/b/op after the handshake without affecting the in-flight result.
- Handshake rules:
  - A requester must hold valid and payload stable until ready.
  - The arbiter never drops an accepted request.
  - Back-pressure through rsp_ready is unbounded.
- ALU semantics:
  - Exactly those of rv32i_alu.
  - Undefined op codes produce result 0 and zero 1, and are not flagged as errors.
  - Shift amount is b[4:0].
  - SLT is signed; SLTU is unsigned.
- Starvation: round-robin mode guarantees a port waits at most one other operation.
- Reset mid-operation: rst_n low in RESP discards the held result. The next cycle shows IDLE with all valids 0 and rr_ptr=0.
- No combinational path from rsp*_ready to any req*_ready.

Decomposition:
- Shared package/header rv32i_defs.vh: `ALU_* opcode constants (existing) plus the arbiter state encoding ARB_IDLE=1'b0, ARB_RESP=1'b1.
- One sub-module: rv32i_alu, instantiated once and fed by a 2:1 operand/op mux.
- Grant logic stays inline.

Test Plan:
- Single-port accept:
  - After reset, port 0 sends a=0x00000005, b=0x00000003, op=`ALU_SUB.
  - Required: req0_ready in the same cycle; next cycle rsp0_valid=1, result=0x00000002, zero=0; rsp1_valid=0.
- Collision with round-robin:
  - Both ports hold valid for 4 ops.
  - Required: grants go 0,1,0,1.
  - Port 1 uses a=0xFFFFFFFF, b=1, op=`ALU_ADD and must see result=0, zero=1.
- Fixed priority:
  - FIXED_PRIO=1 with both ports valid continuously.
  - Required: port 0 granted every time; port 1 ready stays 0.
- Back-pressure:
  - rsp0_ready held 0 for 5 cycles.
  - Required: rsp0_valid/result stable; busy=1; req1_ready=0 throughout.
  - Port 1 is accepted in the cycle after rsp0_ready rises.
- Arithmetic corners:
  - a=0x80000000, b=0x00000021, op=`ALU_SRA -> 0xC0000000 (shift by 1).
  - a=0x80000000, b=0x00000001, op=`ALU_SLT -> 1; op=`ALU_SLTU -> 0.
- Reset mid-RESP:
  - Assert rst_n=0 for 1 cycle while rsp1_valid=1.
  - Required: all rsp*_valid=0 and busy=0 afterwards.
  - A subsequent collision grants port 0 first.
